// File: rtl/tea_core.sv
// TEA block-cipher engine: encrypt or decrypt one 64-bit block under a
// 128-bit key, one Feistel round-pair per clock, valid/ready on both sides.
module tea_core #(
  parameter int unsigned ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          mode,
  input  logic [127:0]  key,
  input  logic [63:0]   data_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   data_out,
  output logic          busy
);

  localparam int unsigned CW = $clog2(ROUNDS + 1);
  // Starting sum for decryption: the encrypt sum after the final round.
  localparam logic [31:0]    SUM_DEC = 32'(DELTA * ROUNDS);
  localparam logic [CW-1:0]  LAST    = CW'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [31:0]    sum;
  logic [31:0]    v0;
  logic [31:0]    v1;
  logic [127:0]   key_q;
  logic           mode_q;

  logic [31:0]    k0, k1, k2, k3;
  logic [31:0]    nv0, nv1, nsum;

  assign k0 = key_q[127:96];
  assign k1 = key_q[95:64];
  assign k2 = key_q[63:32];
  assign k3 = key_q[31:0];

  function automatic logic [31:0] f_mix(input logic [31:0] x, input logic [31:0] s,
                                        input logic [31:0] ka, input logic [31:0] kb);
    return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
  endfunction

  // One round-pair; the second half uses the freshly updated word.
  always_comb begin
    nv0  = v0;
    nv1  = v1;
    nsum = sum;
    if (!mode_q) begin
      nsum = sum + DELTA;
      nv0  = v0 + f_mix(v1, nsum, k0, k1);
      nv1  = v1 + f_mix(nv0, nsum, k2, k3);
    end else begin
      nv1  = v1 - f_mix(v0, sum, k2, k3);
      nv0  = v0 - f_mix(nv1, sum, k0, k1);
      nsum = sum - DELTA;
    end
  end

  // Control FSM, working state and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sum       <= '0;
      v0        <= '0;
      v1        <= '0;
      key_q     <= '0;
      mode_q    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      data_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            key_q    <= key;
            mode_q   <= mode;
            v0       <= data_in[63:32];
            v1       <= data_in[31:0];
            cnt      <= '0;
            sum      <= mode ? SUM_DEC : 32'h0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          v0  <= nv0;
          v1  <= nv1;
          sum <= nsum;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            data_out  <= {nv0, nv1};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tea_core.sv
// Directed bench for tea_core: known vectors, round trips, backpressure,
// single-round configuration and reset abort.
module tb_tea_core;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, mode, out_valid, out_ready, busy;
  logic [127:0]  key;
  logic [63:0]   data_in, data_out;

  logic          r1_in_valid, r1_in_ready, r1_mode, r1_out_valid, r1_out_ready, r1_busy;
  logic [127:0]  r1_key;
  logic [63:0]   r1_data_in, r1_data_out;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] KEY_A = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  localparam logic [63:0]  PT_A  = 64'h12345678_9ABCDEF0;
  localparam logic [63:0]  CT_A  = 64'h5CF85E83_E967E1FD;
  localparam logic [63:0]  CT_0  = 64'h41EA3A0A_94BAA940;

  always #5 clk = ~clk;

  tea_core #(.ROUNDS(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .key(key), .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .busy(busy)
  );

  tea_core #(.ROUNDS(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(r1_in_valid), .in_ready(r1_in_ready), .mode(r1_mode),
    .key(r1_key), .data_in(r1_data_in), .out_valid(r1_out_valid), .out_ready(r1_out_ready),
    .data_out(r1_data_out), .busy(r1_busy)
  );

  // Reference TEA encryption, 32 rounds.
  function automatic logic [63:0] ref_enc(input logic [63:0] d, input logic [127:0] k);
    logic [31:0] a, b, s;
    a = d[63:32]; b = d[31:0]; s = 32'h0;
    for (int i = 0; i < 32; i++) begin
      s = s + 32'h9E3779B9;
      a = a + (((b << 4) + k[127:96]) ^ (b + s) ^ ((b >> 5) + k[95:64]));
      b = b + (((a << 4) + k[63:32]) ^ (a + s) ^ ((a >> 5) + k[31:0]));
    end
    return {a, b};
  endfunction

  // Present a block, scramble inputs after accept, wait (bounded) for out_valid.
  task automatic run_block(input logic m, input logic [127:0] k, input logic [63:0] d,
                           output logic [63:0] res, output int lat);
    in_valid = 1'b1; mode = m; key = k; data_in = d;
    @(posedge clk); #1;
    in_valid = 1'b0; mode = ~m; key = ~k; data_in = ~d;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = data_out;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; mode = 1'b0; key = '0; data_in = '0; out_ready = 1'b0;
    r1_in_valid = 1'b0; r1_mode = 1'b0; r1_key = '0; r1_data_in = '0; r1_out_ready = 1'b0;
    #12;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100 || data_out !== 64'h0) begin
      n_err++;
      $display("FAIL reset_state: rdy/vld/busy=%b data=%h, want 100 data=0",
               {in_ready, out_valid, busy}, data_out);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_encrypt_zero();
    logic [63:0] res; int lat;
    run_block(1'b0, '0, '0, res, lat);
    n_cmp++;
    if (res !== CT_0) begin
      n_err++; $display("FAIL enc_zero_data: got %h want %h", res, CT_0);
    end
    n_cmp++;
    if (lat !== 32) begin
      n_err++; $display("FAIL enc_zero_latency: got %0d want 32", lat);
    end
    n_cmp++;
    if ({in_ready, busy} !== 2'b01) begin
      n_err++; $display("FAIL done_flags: rdy/busy=%b want 01", {in_ready, busy});
    end
    release_out();
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_err++; $display("FAIL return_idle: rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_encrypt_vector();
    logic [63:0] res; int lat;
    run_block(1'b0, KEY_A, PT_A, res, lat);
    n_cmp++;
    if (res !== CT_A || lat !== 32) begin
      n_err++; $display("FAIL enc_vector: got %h lat %0d want %h lat 32", res, lat, CT_A);
    end
    release_out();
  endtask

  task automatic test_decrypt_vector();
    logic [63:0] res; int lat;
    run_block(1'b1, KEY_A, CT_A, res, lat);
    n_cmp++;
    if (res !== PT_A || lat !== 32) begin
      n_err++; $display("FAIL dec_vector: got %h lat %0d want %h lat 32", res, lat, PT_A);
    end
    release_out();
  endtask

  task automatic test_round_trip();
    logic [63:0] pt, ct, back, exp_ct; logic [127:0] k; int lat;
    for (int i = 0; i < 100; i++) begin
      k  = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom};
      exp_ct = ref_enc(pt, k);
      run_block(1'b0, k, pt, ct, lat);
      release_out();
      n_cmp++;
      if (ct !== exp_ct) begin
        n_err++; $display("FAIL rt_enc[%0d]: got %h want %h", i, ct, exp_ct);
      end
      run_block(1'b1, k, ct, back, lat);
      release_out();
      n_cmp++;
      if (back !== pt) begin
        n_err++; $display("FAIL rt_dec[%0d]: got %h want %h", i, back, pt);
      end
    end
  endtask

  task automatic test_rounds1();
    r1_in_valid = 1'b1; r1_mode = 1'b0; r1_key = '0; r1_data_in = '0;
    @(posedge clk); #1;
    r1_in_valid = 1'b0; r1_key = '1; r1_data_in = '1;
    n_cmp++;
    if (r1_out_valid !== 1'b0 || r1_busy !== 1'b1) begin
      n_err++; $display("FAIL r1_early: vld=%b busy=%b want 0 1", r1_out_valid, r1_busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (r1_out_valid !== 1'b1 || r1_data_out !== 64'h9E3779B9_DBE8D32F) begin
      n_err++; $display("FAIL r1_result: vld=%b data=%h want 1 9e3779b9dbe8d32f",
                        r1_out_valid, r1_data_out);
    end
    r1_out_ready = 1'b1;
    @(posedge clk); #1;
    r1_out_ready = 1'b0;
    n_cmp++;
    if (r1_in_ready !== 1'b1 || r1_out_valid !== 1'b0) begin
      n_err++; $display("FAIL r1_release: rdy=%b vld=%b want 1 0", r1_in_ready, r1_out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] res; int lat;
    run_block(1'b0, KEY_A, PT_A, res, lat);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin in_valid = 1'b1; mode = 1'b1; key = '0; data_in = 64'hDEAD_BEEF_0000_0001; end
      if (c == 6) in_valid = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || data_out !== CT_A || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_err++; $display("FAIL stall[%0d]: vld=%b rdy=%b busy=%b data=%h want 1 0 1 %h",
                          c, out_valid, in_ready, busy, data_out, CT_A);
      end
    end
    release_out();
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_err++; $display("FAIL stall_release: rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({in_ready, busy} !== 2'b10) begin
      n_err++; $display("FAIL no_ghost_accept: rdy/busy=%b want 10", {in_ready, busy});
    end
  endtask

  task automatic test_reset_abort();
    logic [63:0] res; int lat;
    in_valid = 1'b1; mode = 1'b0; key = KEY_A; data_in = PT_A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100 || data_out !== 64'h0) begin
      n_err++; $display("FAIL abort_run: rdy/vld/busy=%b data=%h want 100 0",
                        {in_ready, out_valid, busy}, data_out);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL abort_residue: out_valid=%b at cycle %0d want 0", out_valid, c);
        break;
      end
    end
    n_cmp++;
    run_block(1'b0, '0, '0, res, lat);
    n_cmp++;
    if (res !== CT_0 || lat !== 32) begin
      n_err++; $display("FAIL after_abort: got %h lat %0d want %h lat 32", res, lat, CT_0);
    end
    // Reset while holding a result in DONE drops out_valid immediately.
    reset = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL abort_done: vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_encrypt_zero();
    test_encrypt_vector();
    test_decrypt_vector();
    test_rounds1();
    test_backpressure();
    test_reset_abort();
    test_round_trip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tea_core.md
Name: tea_core

Overview:
Parametrised TEA block-cipher engine that handles both encryption and decryption. It takes a 64-bit block, a 128-bit key and a mode bit per transaction, and computes one Feistel round-pair per clock.
It uses valid/ready handshakes on both the input and output sides, so it can sit between a stream source and sink in the crypto datapath.
It replaces the fixed-vector, encrypt-only self-test engine with a general-purpose core.

Parameters:
ROUNDS, 32, number of round-pairs (cycles) per block; legal range 1..64
DELTA, 32'h9E3779B9, key-schedule constant added or subtracted per round

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  reset, asynchronous, active-high
in_valid  input  1  source presents a block
in_ready  output  1  core can accept a block (high only in IDLE)
mode  input  1  0 = encrypt, 1 = decrypt; sampled at accept
key  input  128  k0=key[127:96], k1=key[95:64], k2=key[63:32], k3=key[31:0]; sampled at accept
data_in  input  64  v0=data_in[63:32], v1=data_in[31:0]; sampled at accept
out_valid  output  1  result available
out_ready  input  1  sink accepts result
data_out  output  64  {v0,v1} result, stable while out_valid
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async): state=IDLE, in_ready=1, out_valid=0, busy=0, data_out=0, round counter=0, sum=0.
- Definitions: F(x,s,ka,kb) = ((x<<4)+ka) ^ (x+s) ^ ((x>>5)+kb). All arithmetic is 32-bit modulo 2^32, shifts are logical, and carries are discarded.
- Round counter is $clog2(ROUNDS+1) bits wide.
- IDLE: in_ready=1. Accept occurs on a rising edge with in_valid&&in_ready.
  - On accept, latch key, mode and data, and clear the counter.
  - sum is set to 0 for encrypt, or to (DELTA*ROUNDS) mod 2^32 for decrypt; this constant is computed at elaboration.
  - Go to RUN.
- RUN: one round-pair per cycle. in_ready=0.
  - Encrypt round: sum'=sum+DELTA; v0'=v0+F(v1,sum',k0,k1); v1'=v1+F(v0',sum',k2,k3).
  - Decrypt round: v1'=v1-F(v0,sum,k2,k3); v0'=v0-F(v1',sum,k0,k1); sum'=sum-DELTA.
  - Use the updated v0' and v1' within the same cycle, implemented as a combinational chain.
  - After ROUNDS cycles, load data_out={v0,v1}, set out_valid=1 and go to DONE.
- Latency: accept at edge N gives out_valid high after edge N+ROUNDS.
- DONE: out_valid=1 and data_out is held stable. in_ready=0.
  - On an edge with out_ready=1: out_valid=0, go to IDLE, and in_ready rises after that edge.
  - If out_ready is held low, the core stalls indefinitely with no data change.
- Throughput: at most one block per ROUNDS+2 cycles. No overlap; a second block is never accepted while RUN or DONE.
- in_valid is ignored outside IDLE, and mode/key/data changes after accept have no effect.
- out_ready is ignored outside DONE.
- Reset mid-RUN or mid-DONE aborts the operation. out_valid drops asynchronously, the partial result is discarded, and the core returns to IDLE.
- After reset deassertion, no output appears without a new accept.

Test Plan:
- Encrypt, ROUNDS=32, key=0, data_in=0 -> data_out=64'h41EA3A0A_94BAA940, out_valid exactly 32 cycles after accept edge.
- Encrypt, ROUNDS=32, key={11111111,22222222,33333333,44444444}, data_in=64'h12345678_9ABCDEF0 -> data_out=64'h5CF85E83_E967E1FD.
- Decrypt with the same key and data_in=64'h5CF85E83_E967E1FD -> data_out=64'h12345678_9ABCDEF0. Repeat the encrypt/decrypt round trip for 100 random key/data pairs.
- ROUNDS=1, encrypt, key=0, data_in=0 -> data_out=64'h9E3779B9_DBE8D32F after 1 cycle.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid stays 1, data_out stable, in_ready=0. Pulse in_valid meanwhile with a different block -> not accepted. Release out_ready -> in_ready=1 on the next cycle.
- Reset asserted at round 15 -> out_valid=0, in_ready=1 immediately. A fresh accept then yields the correct result with no residue.
